// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Moore FSM sequencing one car signal head and one pedestrian
//               crossing. Rising edges of the blinker square wave (tick) form
//               the time base; the same wave drives the flashing yellow in
//               fault mode.
//               Optional feature macro: TL_PED_EN (pedestrian request latch,
//               early green exit, ped_ack and ped_walk). When undefined the
//               ped ports remain but ped_req is ignored and ped outputs are 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl #(
  parameter int C_GREEN_TICKS     = 8,
  parameter int C_MIN_GREEN_TICKS = 3,
  parameter int C_YELLOW_TICKS    = 2,
  parameter int C_RED_TICKS       = 6,
  parameter int C_ALLRED_TICKS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       fault,
  output logic       car_red,
  output logic       car_yellow,
  output logic       car_green,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  // Counter must hold the largest duration minus one; one extra bit of headroom.
  localparam int C_MAX_GR  = (C_GREEN_TICKS  > C_RED_TICKS)    ? C_GREEN_TICKS  : C_RED_TICKS;
  localparam int C_MAX_YA  = (C_YELLOW_TICKS > C_ALLRED_TICKS) ? C_YELLOW_TICKS : C_ALLRED_TICKS;
  localparam int C_MAX_ALL = (C_MAX_GR > C_MAX_YA) ? C_MAX_GR : C_MAX_YA;
  localparam int CW        = $clog2(C_MAX_ALL) + 1;

  // Last counter value of each state: the edge seen at this value ends the state.
  localparam logic [CW-1:0] C_GREEN_LAST  = CW'(C_GREEN_TICKS - 1);
  localparam logic [CW-1:0] C_MING_LAST   = CW'(C_MIN_GREEN_TICKS - 1);
  localparam logic [CW-1:0] C_YELLOW_LAST = CW'(C_YELLOW_TICKS - 1);
  localparam logic [CW-1:0] C_RED_LAST    = CW'(C_RED_TICKS - 1);
  localparam logic [CW-1:0] C_ALLRED_LAST = CW'(C_ALLRED_TICKS - 1);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_RED    = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q;
  logic            tick_edge;
  logic            pending;
  logic [CW-1:0]   dur_last;
  logic            dur_done;

  // tick_q resets high so a tick already high at reset release is not an edge.
  assign tick_edge = tick & ~tick_q;

  // Sample the time base for edge detection and for the flashing yellow.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick;
    end
  end

  // Select the final counter value for the current state.
  always_comb begin
    dur_last = C_ALLRED_LAST;
    case (state_q)
      S_ALLRED: dur_last = C_ALLRED_LAST;
      S_GREEN:  dur_last = C_GREEN_LAST;
      S_YELLOW: dur_last = C_YELLOW_LAST;
      S_RED:    dur_last = C_RED_LAST;
      default:  dur_last = C_ALLRED_LAST;
    endcase
  end

  // A pending request shortens GREEN once the minimum green has been served.
  assign dur_done = (cnt_q == dur_last) ||
                    ((state_q == S_GREEN) && pending && (cnt_q >= C_MING_LAST));

  // Next-state and tick counter: fault first, then FLASH exit, then timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault) begin
      state_d = S_FLASH;
      cnt_d   = '0;
    end else if (state_q == S_FLASH) begin
      state_d = S_ALLRED;
      cnt_d   = '0;
    end else if (tick_edge) begin
      if (dur_done) begin
        cnt_d = '0;
        case (state_q)
          S_ALLRED: state_d = S_GREEN;
          S_GREEN:  state_d = S_YELLOW;
          S_YELLOW: state_d = S_RED;
          S_RED:    state_d = S_ALLRED;
          default:  state_d = S_ALLRED;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register and tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ALLRED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TL_PED_EN
  logic pending_q, pending_d;
  logic ped_ack_q, ped_ack_d;

  // Request latch: fault and entry to RED clear it; RED/FLASH ignore the button.
  always_comb begin
    pending_d = pending_q;
    ped_ack_d = 1'b0;
    if (fault) begin
      pending_d = 1'b0;
    end else if ((state_d == S_RED) && (state_q != S_RED)) begin
      pending_d = 1'b0;
    end else if (ped_req && !pending_q &&
                 (state_q != S_RED) && (state_q != S_FLASH)) begin
      pending_d = 1'b1;
      ped_ack_d = 1'b1;
    end
  end

  // Request latch and acknowledge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ped_ack_q <= ped_ack_d;
    end
  end

  assign pending = pending_q;
  assign ped_ack = ped_ack_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign pending        = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  // Lamp decode from the state register only.
  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_walk   = 1'b0;
    case (state_q)
      S_ALLRED: car_red = 1'b1;
      S_GREEN:  car_green = 1'b1;
      S_YELLOW: car_yellow = 1'b1;
      S_RED: begin
        car_red = 1'b1;
`ifdef TL_PED_EN
        ped_walk = 1'b1;
`endif
      end
      S_FLASH:  car_yellow = tick_q;
      default:  car_red = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

`default_nettype wire
